// File: rtl/mult_pkg.sv
`default_nettype none
//============================================================================
// Module   : mult_pkg
// Purpose  : Shared widths and FSM state encoding for the sequential
//            shift-and-add multiplier and its adder datapath.
// Contents : WIDTH  - operand width (8)
//            PWIDTH - product / adder width (16)
//            CNT_W  - iteration counter width (3)
//            state_t - IDLE / RUN / DONE, 2-bit encoding
// Revision : 1.0 - initial release
//============================================================================
package mult_pkg;

  localparam int WIDTH  = 8;
  localparam int PWIDTH = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder16.sv
`default_nettype none
//============================================================================
// Module   : full_adder16
// Purpose  : 16-bit adder/subtractor shared by the multiply datapath.
//            M=0 adds, M=1 computes A - B (two's complement).
// Ports    : A    in  16  operand 1
//            B    in  16  operand 2
//            M    in   1  mode, 0 = add, 1 = subtract
//            S    out 16  sum / difference
//            Cout out  1  carry out of bit 15
// Revision : 1.0 - initial release
//============================================================================
module full_adder16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        M,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] b_eff;
  logic [16:0] sum_ext;

  // Subtract is add of the inverted operand with carry-in of one.
  assign b_eff   = B ^ {16{M}};
  assign sum_ext = {1'b0, A} + {1'b0, b_eff} + {16'b0, M};
  assign S       = sum_ext[15:0];
  assign Cout    = sum_ext[16];

endmodule
`default_nettype wire

// File: rtl/seq_multiplier8.sv
`default_nettype none
//============================================================================
// Module   : seq_multiplier8
// Purpose  : Sequential shift-and-add unsigned multiplier, 8x8 -> 16 bits,
//            built around the shared 16-bit adder. Eight RUN iterations
//            always, then a one-cycle DONE pulse with the product on P.
// Ports    : CLK   in   1  rising-edge clock
//            RST_N in   1  asynchronous active-low reset
//            START in   1  request, sampled only in IDLE
//            A     in   8  multiplicand
//            B     in   8  multiplier
//            P     out 16  product register, holds last result
//            BUSY  out  1  high while not IDLE
//            DONE  out  1  one-cycle pulse when P is updated
// Revision : 1.0 - initial release
//============================================================================
module seq_multiplier8
  import mult_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [PWIDTH-1:0] P,
  output logic              BUSY,
  output logic              DONE
);

  localparam int ITER = WIDTH;

  state_t              state;
  logic [PWIDTH-1:0]   mcand;
  logic [PWIDTH-1:0]   acc;
  logic [WIDTH-1:0]    mplier;
  logic [CNT_W-1:0]    cnt;
  logic [PWIDTH-1:0]   pp;
  logic [PWIDTH-1:0]   sum;
  // An 8x8 product never exceeds 16 bits, so the carry-out has no consumer.
  logic                adder_cout_unused;

  // Partial product: shifted multiplicand gated by the current multiplier LSB.
  assign pp = mplier[0] ? mcand : '0;

  full_adder16 u_adder (acc, pp, 1'b0, sum, adder_cout_unused);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            mcand  <= {{(PWIDTH-WIDTH){1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
            BUSY   <= 1'b1;
          end
        end

        S_RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last iteration: the adder output is the final product.
          if (cnt == CNT_W'(ITER - 1)) begin
            P     <= sum;
            DONE  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
